// File: rtl/mux_arbiter.sv
// -----------------------------------------------------------------------------
// mux_arbiter
//   Round-robin arbiter that owns the shared selection mux / result bus.
//   Up to 8 requesters compete. The winner is announced one cycle after its
//   request (Grant / Selection are registered). Each cycle where the owner
//   still requests is a transfer, and its word appears on Output the cycle
//   after. An owner holding Lock may keep the bus for up to MAX_LOCK
//   consecutive transfers before it is forced to let go.
//
//   Optional build macro: MUX_ARB_FIXED_PRIORITY_EN
//     defined   -> priority pointer pinned at 0 (lowest index always wins)
//     undefined -> round-robin pointer (default)
//
// Ports:
//   Clock       in   rising-edge clock
//   Reset       in   synchronous, active-low reset
//   Request     in   [NUM_REQ]        per-requester "word valid, want bus"
//   Lock        in   [NUM_REQ]        owner keeps bus after this transfer
//   DataIn      in   [NUM_REQ*WIDTH]  requester i word at [i*WIDTH +: WIDTH]
//   Grant       out  [NUM_REQ]        one-hot owner, zero when idle
//   Selection   out  [3]              binary owner index (holds when idle)
//   Output      out  [WIDTH]          registered transferred word
//   OutputValid out  1                Output was transferred last cycle
//   Busy        out  1                OR of Grant
// -----------------------------------------------------------------------------
module mux_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 17,
  parameter int MAX_LOCK = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NUM_REQ-1:0]       Request,
  input  logic [NUM_REQ-1:0]       Lock,
  input  logic [NUM_REQ*WIDTH-1:0] DataIn,
  output logic [NUM_REQ-1:0]       Grant,
  output logic [2:0]               Selection,
  output logic [WIDTH-1:0]         Output,
  output logic                     OutputValid,
  output logic                     Busy
);

  localparam int              LCW       = (MAX_LOCK > 1) ? $clog2(MAX_LOCK) : 1;
  localparam logic [LCW-1:0]  LOCK_LAST = LCW'(MAX_LOCK - 1);
  localparam logic [2:0]      LAST_IDX  = 3'(NUM_REQ - 1);
  localparam logic [3:0]      NUM_REQ_W = 4'(NUM_REQ);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_OWN  = 1'b1;

  // Inputs padded out to a fixed 8-entry view so a 3-bit index is always
  // in range, whatever NUM_REQ is. Padded entries never request.
  logic [7:0]       req_ext;
  logic [7:0]       lock_ext;
  logic [WIDTH-1:0] data_arr [8];

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_unpack
      if (gi < NUM_REQ) begin : g_real
        assign req_ext[gi]  = Request[gi];
        assign lock_ext[gi] = Lock[gi];
        assign data_arr[gi] = DataIn[gi*WIDTH +: WIDTH];
      end else begin : g_pad
        assign req_ext[gi]  = 1'b0;
        assign lock_ext[gi] = 1'b0;
        assign data_arr[gi] = '0;
      end
    end
  endgenerate

  logic [0:0]         state_q,     state_d;
  logic [NUM_REQ-1:0] grant_q,     grant_d;
  logic [2:0]         sel_q,       sel_d;
  logic [2:0]         ptr_q,       ptr_d;
  logic [LCW-1:0]     lock_cnt_q,  lock_cnt_d;
  logic [WIDTH-1:0]   out_q,       out_d;
  logic               out_valid_q, out_valid_d;

  logic       owner_req;
  logic       owner_lock;
  logic       do_arb;
  logic       found;
  logic [2:0] arb_ptr;
  logic [2:0] win;
  logic [3:0] sum;
  logic [7:0] grant_ext;

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    lock_cnt_d  = lock_cnt_q;
    out_d       = out_q;
    out_valid_d = 1'b0;
    do_arb      = 1'b0;
    found       = 1'b0;
    win         = 3'd0;
    sum         = 4'd0;
    arb_ptr     = ptr_q;
    grant_ext   = 8'd0;

    // While owning, sel_q is the owner index, so the owner's inputs are
    // simply the entries at sel_q.
    owner_req  = req_ext[sel_q];
    owner_lock = lock_ext[sel_q];

    if (state_q == ST_OWN && owner_req) begin
      out_d       = data_arr[sel_q];
      out_valid_d = 1'b1;
    end

    if (state_q == ST_IDLE) begin
      do_arb = 1'b1;
    end else if (!owner_req || !owner_lock || lock_cnt_q == LOCK_LAST) begin
      // Release: the old owner drops to lowest priority for this same-cycle
      // re-arbitration, so there is no bubble between owners.
      do_arb     = 1'b1;
      lock_cnt_d = '0;
      arb_ptr    = (sel_q == LAST_IDX) ? 3'd0 : sel_q + 3'd1;
    end else begin
      lock_cnt_d = lock_cnt_q + 1'b1;
    end

`ifdef MUX_ARB_FIXED_PRIORITY_EN
    arb_ptr = 3'd0;
`endif

    if (do_arb) begin
      ptr_d = arb_ptr;
      // Circular search starting at arb_ptr, wrapping modulo NUM_REQ.
      for (int k = 0; k < NUM_REQ; k++) begin
        sum = {1'b0, arb_ptr} + 4'(k);
        if (sum >= NUM_REQ_W) begin
          sum = sum - NUM_REQ_W;
        end
        if (!found && req_ext[sum[2:0]]) begin
          found = 1'b1;
          win   = sum[2:0];
        end
      end
      if (found) begin
        grant_ext = 8'd1 << win;
        state_d   = ST_OWN;
        sel_d     = win;
        grant_d   = grant_ext[NUM_REQ-1:0];
      end else begin
        // Selection deliberately keeps its last value while idle.
        state_d = ST_IDLE;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state_q     <= ST_IDLE;
      grant_q     <= '0;
      sel_q       <= 3'd0;
      ptr_q       <= 3'd0;
      lock_cnt_q  <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      lock_cnt_q  <= lock_cnt_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign Grant       = grant_q;
  assign Selection   = sel_q;
  assign Output      = out_q;
  assign OutputValid = out_valid_q;
  assign Busy        = |grant_q;

endmodule

// File: tb/tb_mux_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mux_arbiter
//   Directed-vector bench for mux_arbiter (NUM_REQ=4, WIDTH=17, MAX_LOCK=8).
//   The stimulus process drives one cycle of inputs at a time and pushes the
//   hand-computed register state expected after the next rising edge, tagged
//   with that edge's number. A separate monitor on the falling edge pops the
//   entries due for the current edge and compares them with the DUT outputs.
// -----------------------------------------------------------------------------
module tb_mux_arbiter;

  localparam int NUM_REQ  = 4;
  localparam int WIDTH    = 17;
  localparam int MAX_LOCK = 8;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_REQ-1:0]       req;
  logic [NUM_REQ-1:0]       lock;
  logic [NUM_REQ*WIDTH-1:0] data_in;
  logic [NUM_REQ-1:0]       grant;
  logic [2:0]               sel;
  logic [WIDTH-1:0]         out_w;
  logic                     out_valid;
  logic                     busy;

  mux_arbiter #(
    .NUM_REQ (NUM_REQ),
    .WIDTH   (WIDTH),
    .MAX_LOCK(MAX_LOCK)
  ) dut (
    .Clock      (clk),
    .Reset      (rst_n),
    .Request    (req),
    .Lock       (lock),
    .DataIn     (data_in),
    .Grant      (grant),
    .Selection  (sel),
    .Output     (out_w),
    .OutputValid(out_valid),
    .Busy       (busy)
  );

  localparam logic [WIDTH-1:0] D0 = 17'd5;
  localparam logic [WIDTH-1:0] D1 = 17'd15;
  localparam logic [WIDTH-1:0] D2 = 17'd5;
  localparam logic [WIDTH-1:0] D3 = 17'h1ABCD;

  typedef struct {
    int               cyc;
    logic [3:0]       g;
    logic [2:0]       s;
    logic [WIDTH-1:0] o;
    logic             ov;
  } exp_t;

  exp_t sb[$];
  int   cycle_cnt = 0;
  int   n_cmp     = 0;
  int   n_fail    = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  // Monitor: compare every expectation that falls due on this edge.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cycle_cnt) begin
      exp_t e;
      e = sb.pop_front();
      n_cmp++;
      if (e.cyc != cycle_cnt || grant !== e.g || sel !== e.s || out_w !== e.o ||
          out_valid !== e.ov || busy !== (|e.g)) begin
        n_fail++;
        $display("FAIL cyc%0d: got grant=%b sel=%0d out=%h ov=%b busy=%b, want grant=%b sel=%0d out=%h ov=%b busy=%b (due cyc%0d)",
                 cycle_cnt, grant, sel, out_w, out_valid, busy,
                 e.g, e.s, e.o, e.ov, |e.g, e.cyc);
      end else begin
        $display("cyc%0d: grant=%b sel=%0d out=%h ov=%b busy=%b ok",
                 cycle_cnt, grant, sel, out_w, out_valid, busy);
      end
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic cyc(input logic rst, input logic [3:0] r, input logic [3:0] l,
                     input logic [3:0] g, input logic [2:0] s,
                     input logic [WIDTH-1:0] o, input logic ov);
    exp_t e;
    rst_n = rst;
    req   = r;
    lock  = l;
    e.cyc = cycle_cnt + 1;
    e.g   = g;
    e.s   = s;
    e.o   = o;
    e.ov  = ov;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    data_in = {D3, D2, D1, D0};
    rst_n   = 1'b0;
    req     = '0;
    lock    = '0;

    // Reset held two cycles with every requester asserting.
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 17'd0, 1'b0);
    cyc(1'b0, 4'b1111, 4'b0000, 4'b0000, 3'd0, 17'd0, 1'b0);

`ifdef MUX_ARB_FIXED_PRIORITY_EN
    // Lowest index keeps winning while it requests.
    cyc(1'b1, 4'b0101, 4'b0000, 4'b0001, 3'd0, 17'd0, 1'b0);
    cyc(1'b1, 4'b0101, 4'b0000, 4'b0001, 3'd0, D0,    1'b1);
    cyc(1'b1, 4'b0101, 4'b0000, 4'b0001, 3'd0, D0,    1'b1);
    cyc(1'b1, 4'b0101, 4'b0000, 4'b0001, 3'd0, D0,    1'b1);
    // Requester 0 drops: no transfer, requester 2 finally wins.
    cyc(1'b1, 4'b0100, 4'b0000, 4'b0100, 3'd2, D0,    1'b0);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd2, D0,    1'b0);
`else
    // Single requester 2: granted, transfers, is re-granted while still
    // requesting on the transfer cycle, then drops and the arbiter idles.
    cyc(1'b1, 4'b0100, 4'b0000, 4'b0100, 3'd2, 17'd0, 1'b0);
    cyc(1'b1, 4'b0100, 4'b0000, 4'b0100, 3'd2, D2,    1'b1);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd2, D2,    1'b0);

    // Round-robin between 0 and 1 (pointer is 3 after owner 2 released).
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0001, 3'd0, D2,    1'b0);
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0010, 3'd1, D0,    1'b1);
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0001, 3'd0, D1,    1'b1);
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0010, 3'd1, D0,    1'b1);
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0001, 3'd0, D1,    1'b1);

    // Lock limit: owner 0 stops requesting, requester 1 wins and locks.
    cyc(1'b1, 4'b1010, 4'b0010, 4'b0010, 3'd1, D1,    1'b0);
    for (int i = 0; i < MAX_LOCK - 1; i++) begin
      cyc(1'b1, 4'b1010, 4'b0010, 4'b0010, 3'd1, D1,  1'b1);
    end
    // Eighth locked transfer forces release straight to requester 3.
    cyc(1'b1, 4'b1010, 4'b0010, 4'b1000, 3'd3, D1,    1'b1);

    // Requester 3 locks for three transfers, then reset mid-lock.
    cyc(1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd3, D3,    1'b1);
    cyc(1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd3, D3,    1'b1);
    cyc(1'b1, 4'b1000, 4'b1000, 4'b1000, 3'd3, D3,    1'b1);
    cyc(1'b0, 4'b1000, 4'b1000, 4'b0000, 3'd0, 17'd0, 1'b0);

    // Pointer back at 0: requester 1 beats 2 (pointer 2 would pick 2).
    cyc(1'b1, 4'b0110, 4'b0000, 4'b0010, 3'd1, 17'd0, 1'b0);
    cyc(1'b1, 4'b0011, 4'b0000, 4'b0001, 3'd0, D1,    1'b1);
    cyc(1'b1, 4'b0000, 4'b0000, 4'b0000, 3'd0, D1,    1'b0);
`endif

    // Let the monitor drain, then make sure nothing was left unchecked.
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
